vga_sync_monitor: RTL and testbench

//  Receive-side counterpart of the VGA output path. Samples a VGA stream (HS, VS,
//  8-bit RRRGGGBB colour) on the pixel strobe and locks to its 640x480 timing.

---
 rtl/vga_sync_monitor.sv | 192 +++++++++++++++++++
 tb/tb_vga_sync_monitor.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_monitor.sv
// Receive-side VGA timing monitor: locks to an incoming HS/VS/colour stream, recovers
// pixel coordinates and data-enable, flags sync timing errors and checksums each frame.
module vga_sync_monitor #(
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_pix_stb,
    input  logic        i_hs,
    input  logic        i_vs,
    input  logic [7:0]  i_color,
    output logic [9:0]  o_x,
    output logic [9:0]  o_y,
    output logic        o_de,
    output logic        o_locked,
    output logic        o_err_h,
    output logic        o_err_v,
    output logic        o_frame_done,
    output logic [15:0] o_checksum
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] L_H_LAST  = 10'(H_TOTAL - 1);
    localparam logic [9:0] L_H_FP    = 10'(H_FP);
    localparam logic [9:0] L_H_SYNC  = 10'(H_SYNC);
    localparam logic [9:0] L_H_START = 10'(H_FP + H_SYNC + H_BP);
    localparam logic [9:0] L_V_LAST  = 10'(V_TOTAL - 1);
    localparam logic [9:0] L_V_ACT   = 10'(V_ACTIVE);
    localparam logic [9:0] L_V_LOAD  = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] L_V_SYNC  = 10'(V_SYNC);
    localparam logic [9:0] L_Y_MAX   = 10'(V_ACTIVE - 1);
    localparam logic [9:0] L_RUN_MAX = 10'h3FF;
    localparam logic [3:0] L_LOCK    = 4'(LOCK_FRAMES);

    localparam logic [1:0] S_SEARCH  = 2'd0;
    localparam logic [1:0] S_MEASURE = 2'd1;
    localparam logic [1:0] S_LOCKED  = 2'd2;

    logic [1:0]  r_state;
    logic [1:0]  w_state_next;
    logic [3:0]  r_good;
    logic [3:0]  w_good_next;
    logic [3:0]  w_good_inc;
    logic [9:0]  r_h_cnt;
    logic [9:0]  r_v_cnt;
    logic [9:0]  r_hs_run;
    logic [9:0]  r_vs_run;
    logic        r_prev_hs;
    logic        r_prev_vs;
    logic [15:0] r_acc;

    logic        w_hs_fall;
    logic        w_hs_rise;
    logic        w_vs_fall;
    logic        w_vs_rise;
    logic        w_h_wrap;
    logic [9:0]  w_h_pred;
    logic [9:0]  w_h_next;
    logic [9:0]  w_v_pred;
    logic [9:0]  w_v_next;
    logic [9:0]  w_vs_run_next;
    logic        w_checking;
    logic        w_herr;
    logic        w_verr;
    logic        w_active;
    logic        w_latch;

    assign w_hs_fall = r_prev_hs & ~i_hs;
    assign w_hs_rise = ~r_prev_hs & i_hs;
    assign w_vs_fall = r_prev_vs & ~i_vs;
    assign w_vs_rise = ~r_prev_vs & i_vs;

    // Predicted positions assume free-running counters; sync edges then re-anchor them.
    assign w_h_pred = (r_h_cnt == L_H_LAST) ? 10'd0 : r_h_cnt + 10'd1;
    assign w_h_wrap = (r_h_cnt == L_H_LAST) && !w_hs_fall;
    assign w_h_next = w_hs_fall ? L_H_FP : w_h_pred;
    assign w_v_pred = w_h_wrap ? ((r_v_cnt == L_V_LAST) ? 10'd0 : r_v_cnt + 10'd1) : r_v_cnt;
    assign w_v_next = w_vs_fall ? L_V_LOAD : w_v_pred;

    // VS low width counts line boundaries crossed while VS was already low.
    assign w_vs_run_next = (w_h_wrap && !r_prev_vs && r_vs_run != L_RUN_MAX)
                           ? r_vs_run + 10'd1 : r_vs_run;

    assign w_checking = (r_state != S_SEARCH);
    assign w_herr = w_checking && ((w_hs_fall && w_h_pred != L_H_FP) ||
                                   (w_hs_rise && r_hs_run != L_H_SYNC));
    assign w_verr = w_checking && ((w_vs_fall && w_v_pred != L_V_LOAD) ||
                                   (w_vs_rise && w_vs_run_next != L_V_SYNC));

    assign w_good_inc = r_good + 4'd1;

    always_comb begin
        w_state_next = r_state;
        w_good_next  = r_good;
        case (r_state)
            S_SEARCH: begin
                if (w_vs_fall) begin
                    w_state_next = S_MEASURE;
                    w_good_next  = 4'd0;
                end
            end
            S_MEASURE: begin
                if (w_herr || w_verr) begin
                    w_state_next = S_SEARCH;
                end else if (w_vs_fall) begin
                    w_good_next = w_good_inc;
                    if (w_good_inc == L_LOCK) begin
                        w_state_next = S_LOCKED;
                    end
                end
            end
            S_LOCKED: begin
                if (w_herr || w_verr) begin
                    w_state_next = S_SEARCH;
                end
            end
            default: w_state_next = S_SEARCH;
        endcase
    end

    assign w_active = (w_h_next >= L_H_START) && (w_v_next < L_V_ACT);
    assign w_latch  = (w_h_next == 10'd0) && (w_v_next == L_V_ACT) && (w_state_next == S_LOCKED);
    assign o_locked = (r_state == S_LOCKED);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= S_SEARCH;
            r_good    <= 4'd0;
            r_h_cnt   <= 10'd0;
            r_v_cnt   <= 10'd0;
            r_hs_run  <= 10'd0;
            r_vs_run  <= 10'd0;
            r_prev_hs <= 1'b1;
            r_prev_vs <= 1'b1;
            r_acc     <= 16'd0;
        end else if (i_pix_stb) begin
            r_state   <= w_state_next;
            r_good    <= w_good_next;
            r_h_cnt   <= w_h_next;
            r_v_cnt   <= w_v_next;
            r_prev_hs <= i_hs;
            r_prev_vs <= i_vs;
            if (w_hs_fall) begin
                r_hs_run <= 10'd1;
            end else if (!i_hs && !r_prev_hs && r_hs_run != L_RUN_MAX) begin
                r_hs_run <= r_hs_run + 10'd1;
            end
            r_vs_run <= w_vs_fall ? 10'd0 : w_vs_run_next;
            if (w_h_next == 10'd0 && w_v_next == 10'd0) begin
                r_acc <= 16'd0;
            end else if (w_active) begin
                r_acc <= r_acc + {8'd0, i_color};
            end
        end
    end

    // Outputs describe the pixel taken on the most recent strobe; pulses last one clock.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_x          <= 10'd0;
            o_y          <= 10'd0;
            o_de         <= 1'b0;
            o_err_h      <= 1'b0;
            o_err_v      <= 1'b0;
            o_frame_done <= 1'b0;
            o_checksum   <= 16'd0;
        end else if (i_pix_stb) begin
            o_x          <= w_active ? (w_h_next - L_H_START) : 10'd0;
            o_y          <= (w_v_next < L_V_ACT) ? w_v_next : L_Y_MAX;
            o_de         <= w_active && (w_state_next == S_LOCKED);
            o_err_h      <= w_herr && (r_state == S_LOCKED);
            o_err_v      <= w_verr && (r_state == S_LOCKED);
            o_frame_done <= w_latch;
            if (w_latch) begin
                o_checksum <= r_acc;
            end
        end else begin
            o_err_h      <= 1'b0;
            o_err_v      <= 1'b0;
            o_frame_done <= 1'b0;
        end
    end
endmodule

// File: tb/tb_vga_sync_monitor.sv
// Self-checking bench for vga_sync_monitor using a reduced raster so whole frames are short.
// A source generator drives the stream and a scoreboard holds the expected per-strobe outputs.
module tb_vga_sync_monitor;
    localparam int HA = 16;
    localparam int HF = 2;
    localparam int HSY = 4;
    localparam int HB = 3;
    localparam int VA = 6;
    localparam int VF = 1;
    localparam int VSY = 2;
    localparam int VB = 2;
    localparam int LOCKF = 2;
    localparam int HT = HA + HF + HSY + HB;
    localparam int VT = VA + VF + VSY + VB;
    localparam int HST = HF + HSY + HB;
    localparam int FRAME = HT * VT;

    typedef struct packed {
        logic [9:0]  x;
        logic [9:0]  y;
        logic        de;
        logic        locked;
        logic        errh;
        logic        errv;
        logic        fd;
        logic [15:0] ck;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_pix_stb;
    logic        i_hs;
    logic        i_vs;
    logic [7:0]  i_color;
    logic [9:0]  o_x;
    logic [9:0]  o_y;
    logic        o_de;
    logic        o_locked;
    logic        o_err_h;
    logic        o_err_v;
    logic        o_frame_done;
    logic [15:0] o_checksum;

    vga_sync_monitor #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
        .LOCK_FRAMES(LOCKF)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_pix_stb(i_pix_stb), .i_hs(i_hs), .i_vs(i_vs),
        .i_color(i_color), .o_x(o_x), .o_y(o_y), .o_de(o_de), .o_locked(o_locked),
        .o_err_h(o_err_h), .o_err_v(o_err_v), .o_frame_done(o_frame_done),
        .o_checksum(o_checksum)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    int          srcH;
    int          srcV;
    int          vsFalls;
    int          shortV;
    logic        shortArmed;
    logic        expLocked;
    logic [15:0] frameSum;
    logic [15:0] lastCk;
    exp_t        sb[$];
    exp_t        lastExp;
    int          fdSeen;
    int          deSeen;
    int          errHSeen;
    logic        sawDe;
    logic [9:0]  firstX;
    logic [9:0]  firstY;
    logic [9:0]  lastX;
    logic [9:0]  lastY;

    // The monitor labels the first post-reset sample h=1, so the source starts there.
    task automatic resetModel();
        srcH       = 1;
        srcV       = 0;
        vsFalls    = 0;
        shortArmed = 1'b0;
        expLocked  = 1'b0;
        frameSum   = 16'd0;
        lastCk     = 16'd0;
        lastExp    = '0;
    endtask

    task automatic applyStimulus(input int mode);
        logic       hs;
        logic       vs;
        logic       act;
        logic       injRise;
        logic [7:0] col;
        exp_t       e;
        hs = !(srcH >= HF && srcH < HF + HSY);
        vs = !(srcV >= VA + VF && srcV < VA + VF + VSY);
        injRise = 1'b0;
        if (shortArmed && srcV == shortV && srcH == HF + HSY - 1) begin
            hs = 1'b1;
            injRise = 1'b1;
            shortArmed = 1'b0;
        end
        act = (srcH >= HST) && (srcV < VA);
        case (mode)
            1:       col = 8'hFF;
            2:       col = act ? 8'(srcH - HST) : 8'(srcH);
            default: col = 8'(srcH * 7 + srcV * 13);
        endcase
        e = '0;
        if (injRise) begin
            e.errh = expLocked;
            expLocked = 1'b0;
            vsFalls = 0;
        end else if (srcH == 0 && srcV == VA + VF) begin
            vsFalls++;
            if (vsFalls >= LOCKF + 1) expLocked = 1'b1;
        end
        if (srcH == 0 && srcV == 0) frameSum = 16'd0;
        else if (act) frameSum = frameSum + {8'd0, col};
        e.fd = (srcH == 0) && (srcV == VA) && expLocked;
        if (e.fd) lastCk = frameSum;
        e.ck     = lastCk;
        e.x      = act ? 10'(srcH - HST) : 10'd0;
        e.y      = (srcV < VA) ? 10'(srcV) : 10'(VA - 1);
        e.de     = act && expLocked;
        e.locked = expLocked;
        sb.push_back(e);
        i_pix_stb = 1'b1;
        i_hs      = hs;
        i_vs      = vs;
        i_color   = col;
        if (srcH == HT - 1) begin
            srcH = 0;
            srcV = (srcV == VT - 1) ? 0 : srcV + 1;
        end else begin
            srcH = srcH + 1;
        end
        @(negedge clk);
    endtask

    task automatic checkOutput();
        exp_t e;
        exp_t obs;
        obs = {o_x, o_y, o_de, o_locked, o_err_h, o_err_v, o_frame_done, o_checksum};
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $error("[TB] FAIL scoreboard_empty: got %h required an entry", obs);
            return;
        end
        e = sb.pop_front();
        lastExp = e;
        assert (obs === e) else begin
            failures++;
            $error("[TB] FAIL pixel: got x=%0d y=%0d flags=%b ck=%h, required x=%0d y=%0d flags=%b ck=%h",
                   obs.x, obs.y, {obs.de, obs.locked, obs.errh, obs.errv, obs.fd}, obs.ck,
                   e.x, e.y, {e.de, e.locked, e.errh, e.errv, e.fd}, e.ck);
        end
        fdSeen   += int'(o_frame_done);
        errHSeen += int'(o_err_h);
        if (o_de) begin
            deSeen++;
            if (!sawDe) begin
                firstX = o_x;
                firstY = o_y;
                sawDe  = 1'b1;
            end
            lastX = o_x;
            lastY = o_y;
        end
    endtask

    task automatic idleCheck(input int gap);
        logic [22:0] obs;
        logic [22:0] req;
        if (gap <= 0) return;
        i_pix_stb = 1'b0;
        @(negedge clk);
        obs = {o_err_h, o_err_v, o_frame_done, o_x, o_y};
        req = {3'b000, lastExp.x, lastExp.y};
        checks++;
        assert (obs === req) else begin
            failures++;
            $error("[TB] FAIL idle_hold: got %h required %h", obs, req);
        end
        repeat (gap - 1) @(negedge clk);
    endtask

    task automatic runSamples(input int n, input int mode, input int gap);
        for (int i = 0; i < n; i++) begin
            applyStimulus(mode);
            checkOutput();
            idleCheck(gap < 0 ? int'($urandom_range(1, 3)) : gap);
        end
    endtask

    task automatic checkValue(input string tag, input int got, input int req);
        checks++;
        assert (got === req) else begin
            failures++;
            $error("[TB] FAIL %s: got %0d required %0d", tag, got, req);
        end
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [40:0] allOut;
        resetModel();
        rst = 1'b1;
        i_pix_stb = 1'b0;
        i_hs = 1'b1;
        i_vs = 1'b1;
        i_color = 8'd0;
        repeat (3) @(negedge clk);
        allOut = {o_x, o_y, o_de, o_locked, o_err_h, o_err_v, o_frame_done, o_checksum};
        checkValue("reset_outputs_zero", int'(allOut != 41'd0), 0);
        rst = 1'b0;
        @(negedge clk);

        // Lock rises on the third VS fall, at the end of frame 2.
        runSamples(3 * FRAME, 0, 0);
        checkValue("locked_after_three_frames", int'(o_locked), 1);

        // Constant white frame: 96 active pixels * 255.
        fdSeen = 0;
        runSamples(FRAME, 1, 0);
        checkValue("white_frame_done_count", fdSeen, 1);
        checkValue("white_checksum", int'(o_checksum), 16'h5FA0);

        // Colour follows x: sum of 0..15 on six lines.
        fdSeen = 0;
        deSeen = 0;
        sawDe  = 1'b0;
        runSamples(FRAME, 2, 0);
        checkValue("de_count", deSeen, HA * VA);
        checkValue("first_de_x", int'(firstX), 0);
        checkValue("first_de_y", int'(firstY), 0);
        checkValue("last_de_x", int'(lastX), HA - 1);
        checkValue("last_de_y", int'(lastY), VA - 1);
        checkValue("xramp_checksum", int'(o_checksum), 16'h02D0);

        // Short HS low run while locked: error pulse, no latch for the broken frame.
        fdSeen = 0;
        errHSeen = 0;
        shortArmed = 1'b1;
        shortV = 2;
        runSamples(FRAME, 1, 0);
        checkValue("short_hs_err_pulses", errHSeen, 1);
        checkValue("broken_frame_no_latch", fdSeen, 0);
        checkValue("broken_frame_checksum_held", int'(o_checksum), 16'h02D0);
        runSamples(2 * FRAME, 2, 0);
        checkValue("relocked", int'(o_locked), 1);
        runSamples(FRAME, 1, 0);
        checkValue("relock_checksum", int'(o_checksum), 16'h5FA0);

        // Asynchronous reset between clock edges, mid-line.
        runSamples(60, 2, 0);
        i_pix_stb = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        allOut = {o_x, o_y, o_de, o_locked, o_err_h, o_err_v, o_frame_done, o_checksum};
        checkValue("async_reset_outputs_zero", int'(allOut != 41'd0), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        resetModel();
        @(negedge clk);
        checkValue("search_after_reset", int'(o_locked), 0);

        // Slower and irregular strobes must give the same per-strobe results.
        runSamples(3 * FRAME, 1, 3);
        checkValue("locked_stb_every_4", int'(o_locked), 1);
        runSamples(2 * FRAME, 2, -1);
        checkValue("irregular_stb_checksum", int'(o_checksum), 16'h02D0);
        checkValue("scoreboard_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
